div_ctrl: RTL and testbench
===========================

# div_ctrl

Controller FSM for the 8-bit restoring divider, sitting directly upstream of the divider datapath. It sequences the datapath's load/init/shift strobes from a single `start` request, reads the datapath's `MostOut` sign flag each iteration, and reports completion with a one-cycle `done` pulse. Quotient and remainder stay in the datapath registers.

## Interface
- `WIDTH`, default 8: operand width, which is also the iteration count.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: division request, sampled only in IDLE.
- `dz` input 1: divisor-is-zero flag from upstream, valid with `start`.
- `MostOut` input 1: datapath sign of (A − M); 1 means negative, so no load.
- `LoadM` output 1: load divisor register.
- `InitA` output 1: clear the A register.
- `LoadQ` output 1: Q write; its function is selected by `LeastSel`.
- `LeastSel` output 1: 0 means `LoadQ` loads the external dividend; 1 means `LoadQ` sets Q[0]=1 and holds the other bits.
- `LoadA` output 1: load A with the datapath A − M result.
- `ShiftAQ` output 1: shift {A,Q} left by one, with 0 entering Q[0].
- `busy` output 1: high in INIT, SHIFT and TEST.
- `done` output 1: one-cycle pulse in DONE.
- `err` output 1: divide-by-zero, valid while `done` is high.

## Operation
- States: IDLE, INIT, SHIFT, TEST, DONE.
- IDLE: all strobes 0. On `start`=1 go to INIT. Exception: with `DIV_ZERO_DETECT_EN` and `dz`=1, go straight to DONE with the error flag set.
- INIT: `LoadM`=`InitA`=`LoadQ`=1 and `LeastSel`=0. Clear the iteration counter. Go to SHIFT.
- SHIFT: `ShiftAQ`=1. Go to TEST.
- TEST, combinational on `MostOut`:
  - `MostOut`=0: `LoadA`=`LoadQ`=`LeastSel`=1, which subtracts and sets the quotient bit to 1.
  - `MostOut`=1: all strobes 0. A is not loaded, so the restore is implicit and the quotient bit stays 0.
  - Counter increments. If the counter equals WIDTH−1, go to DONE; otherwise go to SHIFT.
- DONE: `done`=1 and `err`=error flag. Go to IDLE unconditionally.
- `start` outside IDLE is ignored, with no queuing. `start` held high across DONE is accepted again on the IDLE cycle that follows.
- Strobes are mutually consistent: at most one of {`ShiftAQ`, `LoadA`/`LoadQ`} group per cycle. `InitA` only appears in INIT.
- All strobes are decoded from state, except the TEST outputs, which are Mealy on `MostOut`.
- Counter width is $clog2(WIDTH); it wraps only through INIT clearing it.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, counter 0, error flag 0. All outputs 0: `LoadM`, `InitA`, `LoadQ`, `LeastSel`, `LoadA`, `ShiftAQ`, `busy`, `done`, `err`.
- Reset mid-operation aborts at once. Datapath contents are then undefined, and the next `start` fully re-initialises them.
- Normal latency with `start` sampled at edge k:
  - INIT during cycle k→k+1.
  - WIDTH iterations of SHIFT+TEST, which is 16 cycles for WIDTH=8.
  - DONE during cycle k+17→k+18.
  - Results are valid in the datapath from edge k+17 onward.
- Divide-by-zero path (macro on): DONE during cycle k→k+1, with `err`=1 and no datapath strobes.
- Minimum `start`-to-`start` spacing: WIDTH·2+3 cycles.

## Configuration
- Macro: `DIV_ZERO_DETECT_EN`.
- Defined: `dz` is sampled with `start`. `dz`=1 skips INIT and the iterations, pulses `done` with `err`=1, and leaves the datapath untouched.
- Undefined: `dz` is ignored and `err` is tied to 0. Division by zero runs the full sequence, which yields quotient all-ones and remainder equal to the dividend.
- Ports are identical in both builds.

## Structure
- Shared package `div_pkg` holds:
  - the `div_state_t` enum (IDLE, INIT, SHIFT, TEST, DONE);
  - the `DIV_WIDTH`=8 constant;
  - the counter-width localparam function.
- One natural sub-module, `div_cnt`: the iteration counter, with a clear in INIT, an increment in TEST, and a last-iteration flag output.
- The FSM and strobe decode stay in `div_ctrl`.

## Test plan
The bench pairs `div_ctrl` with a behavioural datapath model.
- Dividend 212, divisor 7, one-cycle `start` → `done` exactly 18 cycles later; Q=30, R=2; `err`=0.
- Dividend 255, divisor 1 → Q=255, R=0. `LoadA` is asserted in all 8 TEST cycles.
- Dividend 5, divisor 9 → Q=0, R=5. `LoadA` is never asserted, and there are exactly 8 `ShiftAQ` pulses.
- `start` re-pulsed at cycles 3 and 10 during a 212/7 run → ignored; a single `done`, at the same cycle as the undisturbed run.
- `rst` driven low 6 cycles into a run → all outputs 0 asynchronously. A new 100/3 request then gives Q=33, R=1.
- Divisor-zero request (`dz`=1, dividend 40):
  - macro on: `done`+`err` in the next cycle, with no strobes;
  - macro off: 18-cycle run, Q=255, R=40, `err`=0.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the restoring divider controller
//
// Contents:
//   DIV_WIDTH   - default operand width, which is also the iteration count
//   div_state_t - controller state encoding (IDLE, INIT, SHIFT, TEST, DONE)
//   cnt_width() - width of the iteration counter for a given operand width
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    TEST  = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  // Keep at least one bit so a WIDTH of 1 still yields a legal vector.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_cnt.sv
// rtl/div_cnt.sv - iteration counter for the divider controller
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   clr  - clear the count to 0 (asserted in INIT)
//   inc  - advance the count by one (asserted in TEST)
//   last - high while the count equals WIDTH-1, i.e. the final iteration
module div_cnt
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The increment after the last iteration may wrap; INIT clears it
  // before the count is used again.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - controller FSM sequencing the 8-bit restoring divider datapath
//
// Optional feature macro: DIV_ZERO_DETECT_EN (divide-by-zero short-cut).
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - division request, sampled only in IDLE
//   dz       - divisor-is-zero flag, valid with start
//   MostOut  - datapath sign of (A - M); 1 = negative, do not load A
//   LoadM    - load divisor register
//   InitA    - clear A
//   LoadQ    - write Q (dividend when LeastSel=0, set Q[0] when LeastSel=1)
//   LeastSel - LoadQ function select
//   LoadA    - load A with A - M
//   ShiftAQ  - shift {A,Q} left, 0 into Q[0]
//   busy     - high in INIT, SHIFT and TEST
//   done     - one-cycle completion pulse
//   err      - divide-by-zero, valid with done
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dz,
  input  logic MostOut,
  output logic LoadM,
  output logic InitA,
  output logic LoadQ,
  output logic LeastSel,
  output logic LoadA,
  output logic ShiftAQ,
  output logic busy,
  output logic done,
  output logic err
);

  div_state_t state_q;
  div_state_t state_d;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;

`ifdef DIV_ZERO_DETECT_EN
  logic       err_q;
  logic       err_d;
`else
  logic       unused_dz;
  assign unused_dz = dz;
`endif

  div_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    LoadM    = 1'b0;
    InitA    = 1'b0;
    LoadQ    = 1'b0;
    LeastSel = 1'b0;
    LoadA    = 1'b0;
    ShiftAQ  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          // A zero divisor bypasses the datapath entirely.
          if (dz) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = INIT;
          end
`else
          state_d = INIT;
`endif
        end
      end
      INIT: begin
        LoadM   = 1'b1;
        InitA   = 1'b1;
        LoadQ   = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        ShiftAQ = 1'b1;
        busy    = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        busy    = 1'b1;
        cnt_inc = 1'b1;
        // Non-negative trial difference: commit it and set the quotient
        // bit. Negative: leave A alone, which is the implicit restore.
        if (!MostOut) begin
          LoadA    = 1'b1;
          LoadQ    = 1'b1;
          LeastSel = 1'b1;
        end
        state_d = cnt_last ? DONE : SHIFT;
      end
      DONE: begin
        done    = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
        err     = err_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - div_ctrl paired with a behavioural restoring-divider datapath
module tb_div_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic dz;
  logic MostOut;
  logic LoadM;
  logic InitA;
  logic LoadQ;
  logic LeastSel;
  logic LoadA;
  logic ShiftAQ;
  logic busy;
  logic done;
  logic err;

  int checks = 0;
  int errors = 0;

  // Datapath model: 9-bit A so the trial difference never overflows.
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [8:0] a_reg;
  logic [7:0] q_reg;
  logic [7:0] m_reg;
  logic [9:0] diff;

  assign diff    = {1'b0, a_reg} - {2'b00, m_reg};
  assign MostOut = diff[9];

  always @(posedge clk) begin
    if (LoadM) m_reg <= divisor;
    if (InitA) a_reg <= '0;
    if (ShiftAQ) {a_reg, q_reg} <= {a_reg[7:0], q_reg, 1'b0};
    if (LoadA) a_reg <= diff[8:0];
    if (LoadQ) q_reg <= LeastSel ? {q_reg[7:1], 1'b1} : dividend;
  end

  div_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dz       (dz),
    .MostOut  (MostOut),
    .LoadM    (LoadM),
    .InitA    (InitA),
    .LoadQ    (LoadQ),
    .LeastSel (LeastSel),
    .LoadA    (LoadA),
    .ShiftAQ  (ShiftAQ),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request from a negedge and observes each cycle at the
  // following negedge. Edge 1 is the edge that samples start.
  task automatic run_div(input logic [7:0] dvd, input logic [7:0] dvs,
                         input logic dzv, input bit repulse,
                         output int done_at, output int done_cnt,
                         output int la_cnt, output int sh_cnt,
                         output int strobe_cnt, output logic err_at,
                         output int conflicts);
    dividend   = dvd;
    divisor    = dvs;
    dz         = dzv;
    start      = 1'b1;
    done_at    = -1;
    done_cnt   = 0;
    la_cnt     = 0;
    sh_cnt     = 0;
    strobe_cnt = 0;
    err_at     = 1'b0;
    conflicts  = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = repulse && (e == 2 || e == 9);
      if (LoadA) la_cnt++;
      if (ShiftAQ) sh_cnt++;
      if (LoadM || InitA || LoadQ || LoadA || ShiftAQ) strobe_cnt++;
      if (ShiftAQ && (LoadA || LoadQ)) conflicts++;
      if (InitA && !(LoadM && LoadQ && !LeastSel)) conflicts++;
      if (err && !done) conflicts++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = e;
          err_at  = err;
        end
      end
      if (done_at >= 0 && e >= done_at + 3) break;
    end
    start = 1'b0;
    dz    = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    start    = 1'b0;
    dz       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({LoadM, InitA, LoadQ, LeastSel, LoadA, ShiftAQ, busy, done, err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b",
               {LoadM, InitA, LoadQ, LeastSel, LoadA, ShiftAQ, busy, done, err}, 9'b0);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_212_7;
    int da, dc, la, sh, sc, cf;
    logic ea;
    run_div(8'd212, 8'd7, 1'b0, 1'b0, da, dc, la, sh, sc, ea, cf);
    checks++;
    if (da !== 18) begin errors++; $display("FAIL d212_latency got=%0d want=18", da); end
    checks++;
    if (q_reg !== 8'd30) begin errors++; $display("FAIL d212_q got=%0d want=30", q_reg); end
    checks++;
    if (a_reg !== 9'd2) begin errors++; $display("FAIL d212_r got=%0d want=2", a_reg); end
    checks++;
    if (ea !== 1'b0) begin errors++; $display("FAIL d212_err got=%b want=0", ea); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL d212_done_count got=%0d want=1", dc); end
    checks++;
    if (cf !== 0) begin errors++; $display("FAIL d212_strobe_conflicts got=%0d want=0", cf); end
  endtask

  task automatic test_all_ones;
    int da, dc, la, sh, sc, cf;
    logic ea;
    run_div(8'd255, 8'd1, 1'b0, 1'b0, da, dc, la, sh, sc, ea, cf);
    checks++;
    if (q_reg !== 8'd255) begin errors++; $display("FAIL d255_q got=%0d want=255", q_reg); end
    checks++;
    if (a_reg !== 9'd0) begin errors++; $display("FAIL d255_r got=%0d want=0", a_reg); end
    checks++;
    if (la !== 8) begin errors++; $display("FAIL d255_loada_count got=%0d want=8", la); end
  endtask

  task automatic test_no_subtract;
    int da, dc, la, sh, sc, cf;
    logic ea;
    run_div(8'd5, 8'd9, 1'b0, 1'b0, da, dc, la, sh, sc, ea, cf);
    checks++;
    if (q_reg !== 8'd0) begin errors++; $display("FAIL d5_q got=%0d want=0", q_reg); end
    checks++;
    if (a_reg !== 9'd5) begin errors++; $display("FAIL d5_r got=%0d want=5", a_reg); end
    checks++;
    if (la !== 0) begin errors++; $display("FAIL d5_loada_count got=%0d want=0", la); end
    checks++;
    if (sh !== 8) begin errors++; $display("FAIL d5_shift_count got=%0d want=8", sh); end
  endtask

  task automatic test_back_to_back;
    int da, dc, la, sh, sc, cf;
    logic ea;
    run_div(8'd212, 8'd7, 1'b0, 1'b1, da, dc, la, sh, sc, ea, cf);
    checks++;
    if (da !== 18) begin errors++; $display("FAIL repulse_latency got=%0d want=18", da); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL repulse_done_count got=%0d want=1", dc); end
    checks++;
    if (q_reg !== 8'd30) begin errors++; $display("FAIL repulse_q got=%0d want=30", q_reg); end
  endtask

  task automatic test_reset_mid_run;
    int da, dc, la, sh, sc, cf;
    logic ea;
    dividend = 8'd212;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b want=1", busy); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({LoadM, InitA, LoadQ, LeastSel, LoadA, ShiftAQ, busy, done, err} !== 9'b0) begin
      errors++;
      $display("FAIL midrun_reset_outputs got=%b want=%b",
               {LoadM, InitA, LoadQ, LeastSel, LoadA, ShiftAQ, busy, done, err}, 9'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div(8'd100, 8'd3, 1'b0, 1'b0, da, dc, la, sh, sc, ea, cf);
    checks++;
    if (q_reg !== 8'd33) begin errors++; $display("FAIL d100_q got=%0d want=33", q_reg); end
    checks++;
    if (a_reg !== 9'd1) begin errors++; $display("FAIL d100_r got=%0d want=1", a_reg); end
  endtask

  task automatic test_div_zero;
    int da, dc, la, sh, sc, cf;
    logic ea;
    run_div(8'd40, 8'd0, 1'b1, 1'b0, da, dc, la, sh, sc, ea, cf);
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (da !== 1) begin errors++; $display("FAIL dz_latency got=%0d want=1", da); end
    checks++;
    if (ea !== 1'b1) begin errors++; $display("FAIL dz_err got=%b want=1", ea); end
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL dz_strobes got=%0d want=0", sc); end
    checks++;
    if (q_reg !== 8'd33 || a_reg !== 9'd1) begin
      errors++;
      $display("FAIL dz_datapath_kept got=%0d/%0d want=33/1", q_reg, a_reg);
    end
`else
    checks++;
    if (da !== 18) begin errors++; $display("FAIL dz_latency got=%0d want=18", da); end
    checks++;
    if (ea !== 1'b0) begin errors++; $display("FAIL dz_err got=%b want=0", ea); end
    checks++;
    if (q_reg !== 8'd255) begin errors++; $display("FAIL dz_q got=%0d want=255", q_reg); end
    checks++;
    if (a_reg !== 9'd40) begin errors++; $display("FAIL dz_r got=%0d want=40", a_reg); end
`endif
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL dz_done_count got=%0d want=1", dc); end
  endtask

  initial begin
    test_reset();
    test_basic_212_7();
    test_all_ones();
    test_no_subtract();
    test_back_to_back();
    test_reset_mid_run();
    test_div_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
